// File: rtl/uart_core.sv
// UART transceiver: 5-8 data bits, optional even/odd parity, 1/2 stop bits, buffered TX and RX.
// TX line falls two cycles after a push into an idle FIFO; RX pushes on the first stop-bit sample and drops frames when full.

// Circular buffer with registered occupancy; accepts a push while full when a pop happens in the same cycle.
module uart_fifo #(
    parameter int DEPTH = 8,
    parameter int W     = 8
) (
    input  logic                   clk_i,
    input  logic                   arst_ni,
    input  logic                   push_i,
    input  logic [W-1:0]           wdat_i,
    input  logic                   pop_i,
    output logic [W-1:0]           rdat_o,
    output logic                   full_o,
    output logic                   empty_o,
    output logic [$clog2(DEPTH):0] count_o
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          wr_en, rd_en;

    assign full_o  = (count_q == (AW+1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign rd_en   = pop_i && !empty_o;
    assign wr_en   = push_i && (!full_o || rd_en);
    assign count_o = count_q;
    assign rdat_o  = empty_o ? '0 : mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (wr_en) wr_ptr_d = wr_ptr_q + AW'(1);
        if (rd_en) rd_ptr_d = rd_ptr_q + AW'(1);
        case ({wr_en, rd_en})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (wr_en) mem_q[wr_ptr_q] <= wdat_i;
    end

    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end
endmodule

module uart_core #(
    parameter int TX_FIFO_DEPTH = 8,
    parameter int RX_FIFO_DEPTH = 8,
    parameter int DIV_W         = 16
) (
    input  logic                           clk_i,
    input  logic                           arst_ni,
    input  logic [DIV_W-1:0]               clk_div_i,
    input  logic [1:0]                     data_bits_i,
    input  logic                           parity_en_i,
    input  logic                           parity_type_i,
    input  logic                           stop2_i,
    input  logic [7:0]                     tx_data_i,
    input  logic                           tx_valid_i,
    output logic                           tx_ready_o,
    output logic [$clog2(TX_FIFO_DEPTH):0] tx_count_o,
    output logic                           tx_busy_o,
    output logic [7:0]                     rx_data_o,
    output logic                           rx_parity_err_o,
    output logic                           rx_frame_err_o,
    output logic                           rx_valid_o,
    input  logic                           rx_ready_i,
    output logic [$clog2(RX_FIFO_DEPTH):0] rx_count_o,
    output logic                           rx_overrun_o,
    output logic                           tx_o,
    input  logic                           rx_i
);
    typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP1, TX_STOP2} tx_state_e;
    typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP, RX_WAIT_HIGH} rx_state_e;

    logic [DIV_W-1:0] div_eff;
    logic [7:0]       data_mask;
    logic [2:0]       last_bit_cfg;

    assign div_eff      = (clk_div_i < DIV_W'(4)) ? DIV_W'(4) : clk_div_i;
    assign last_bit_cfg = 3'd4 + {1'b0, data_bits_i};

    always_comb begin
        case (data_bits_i)
            2'd0:    data_mask = 8'h1F;
            2'd1:    data_mask = 8'h3F;
            2'd2:    data_mask = 8'h7F;
            default: data_mask = 8'hFF;
        endcase
    end

    logic [7:0] tx_fifo_dat;
    logic       tx_fifo_full, tx_fifo_empty, tx_pop;

    assign tx_ready_o = !tx_fifo_full;

    uart_fifo #(.DEPTH(TX_FIFO_DEPTH), .W(8)) u_tx_fifo (
        .clk_i   (clk_i),
        .arst_ni (arst_ni),
        .push_i  (tx_valid_i && tx_ready_o),
        .wdat_i  (tx_data_i),
        .pop_i   (tx_pop),
        .rdat_o  (tx_fifo_dat),
        .full_o  (tx_fifo_full),
        .empty_o (tx_fifo_empty),
        .count_o (tx_count_o)
    );

    tx_state_e        tx_state_q, tx_state_d;
    logic [DIV_W-1:0] tx_cnt_q, tx_cnt_d, tx_div_q, tx_div_d;
    logic [2:0]       tx_bit_q, tx_bit_d, tx_last_q, tx_last_d;
    logic [7:0]       tx_shift_q, tx_shift_d;
    logic             tx_par_q, tx_par_d, tx_pen_q, tx_pen_d, tx_stop2_q, tx_stop2_d;
    logic             tx_line_q, tx_line_d;
    logic             tx_bit_end, tx_load;

    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q;
        tx_div_d   = tx_div_q;
        tx_bit_d   = tx_bit_q;
        tx_last_d  = tx_last_q;
        tx_shift_d = tx_shift_q;
        tx_par_d   = tx_par_q;
        tx_pen_d   = tx_pen_q;
        tx_stop2_d = tx_stop2_q;
        tx_pop     = 1'b0;
        tx_load    = 1'b0;
        tx_bit_end = (tx_cnt_q == tx_div_q - DIV_W'(1));
        if (tx_state_q != TX_IDLE) tx_cnt_d = tx_bit_end ? '0 : tx_cnt_q + DIV_W'(1);
        case (tx_state_q)
            TX_IDLE:   tx_load = !tx_fifo_empty;
            TX_START:  if (tx_bit_end) tx_state_d = TX_DATA;
            TX_DATA: begin
                if (tx_bit_end) begin
                    tx_shift_d = tx_shift_q >> 1;
                    tx_bit_d   = tx_bit_q + 3'd1;
                    if (tx_bit_q == tx_last_q) tx_state_d = tx_pen_q ? TX_PARITY : TX_STOP1;
                end
            end
            TX_PARITY: if (tx_bit_end) tx_state_d = TX_STOP1;
            TX_STOP1: begin
                if (tx_bit_end) begin
                    tx_state_d = tx_stop2_q ? TX_STOP2 : TX_IDLE;
                    tx_load    = !tx_stop2_q && !tx_fifo_empty;
                end
            end
            TX_STOP2: begin
                if (tx_bit_end) begin
                    tx_state_d = TX_IDLE;
                    tx_load    = !tx_fifo_empty;
                end
            end
            default:   tx_state_d = TX_IDLE;
        endcase
        // Back-to-back frames reload straight out of the last stop bit.
        if (tx_load) begin
            tx_pop     = 1'b1;
            tx_state_d = TX_START;
            tx_cnt_d   = '0;
            tx_bit_d   = '0;
            tx_div_d   = div_eff;
            tx_last_d  = last_bit_cfg;
            tx_shift_d = tx_fifo_dat & data_mask;
            tx_par_d   = (^(tx_fifo_dat & data_mask)) ^ parity_type_i;
            tx_pen_d   = parity_en_i;
            tx_stop2_d = stop2_i;
        end
        case (tx_state_d)
            TX_START:  tx_line_d = 1'b0;
            TX_DATA:   tx_line_d = tx_shift_d[0];
            TX_PARITY: tx_line_d = tx_par_d;
            default:   tx_line_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            tx_state_q <= TX_IDLE;
            tx_cnt_q   <= '0;
            tx_div_q   <= DIV_W'(4);
            tx_bit_q   <= '0;
            tx_last_q  <= '0;
            tx_shift_q <= '0;
            tx_par_q   <= 1'b0;
            tx_pen_q   <= 1'b0;
            tx_stop2_q <= 1'b0;
            tx_line_q  <= 1'b1;
        end else begin
            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_div_q   <= tx_div_d;
            tx_bit_q   <= tx_bit_d;
            tx_last_q  <= tx_last_d;
            tx_shift_q <= tx_shift_d;
            tx_par_q   <= tx_par_d;
            tx_pen_q   <= tx_pen_d;
            tx_stop2_q <= tx_stop2_d;
            tx_line_q  <= tx_line_d;
        end
    end

    assign tx_o      = tx_line_q;
    assign tx_busy_o = (tx_state_q != TX_IDLE);

    rx_state_e        rx_state_q, rx_state_d;
    logic [1:0]       rx_sync_q;
    logic [DIV_W-1:0] rx_cnt_q, rx_cnt_d, rx_div_q, rx_div_d;
    logic [2:0]       rx_bit_q, rx_bit_d, rx_last_q, rx_last_d;
    logic [7:0]       rx_data_q, rx_data_d;
    logic             rx_pen_q, rx_pen_d, rx_odd_q, rx_odd_d;
    logic             rx_par_q, rx_par_d, rx_perr_q, rx_perr_d;
    logic             rx_ovr_q, rx_ovr_d;
    logic             rx_line, rx_samp, rx_half, rx_push;
    logic             rx_fifo_full, rx_fifo_empty;

    assign rx_line = rx_sync_q[1];

    always_comb begin
        rx_state_d = rx_state_q;
        rx_cnt_d   = rx_cnt_q;
        rx_div_d   = rx_div_q;
        rx_bit_d   = rx_bit_q;
        rx_last_d  = rx_last_q;
        rx_data_d  = rx_data_q;
        rx_pen_d   = rx_pen_q;
        rx_odd_d   = rx_odd_q;
        rx_par_d   = rx_par_q;
        rx_perr_d  = rx_perr_q;
        rx_push    = 1'b0;
        rx_samp    = (rx_cnt_q == rx_div_q - DIV_W'(1));
        rx_half    = (rx_cnt_q == (rx_div_q >> 1) - DIV_W'(1));
        if (rx_state_q inside {RX_START, RX_DATA, RX_PARITY, RX_STOP})
            rx_cnt_d = rx_cnt_q + DIV_W'(1);
        case (rx_state_q)
            RX_IDLE: begin
                if (!rx_line) begin
                    rx_state_d = RX_START;
                    rx_cnt_d   = '0;
                    rx_div_d   = div_eff;
                    rx_last_d  = last_bit_cfg;
                    rx_pen_d   = parity_en_i;
                    rx_odd_d   = parity_type_i;
                    rx_bit_d   = '0;
                    rx_data_d  = '0;
                    rx_par_d   = 1'b0;
                    rx_perr_d  = 1'b0;
                end
            end
            RX_START: begin
                if (rx_half) begin
                    rx_cnt_d   = '0;
                    rx_state_d = rx_line ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                if (rx_samp) begin
                    rx_cnt_d            = '0;
                    rx_data_d[rx_bit_q] = rx_line;
                    rx_par_d            = rx_par_q ^ rx_line;
                    rx_bit_d            = rx_bit_q + 3'd1;
                    if (rx_bit_q == rx_last_q) rx_state_d = rx_pen_q ? RX_PARITY : RX_STOP;
                end
            end
            RX_PARITY: begin
                if (rx_samp) begin
                    rx_cnt_d   = '0;
                    rx_perr_d  = rx_line ^ rx_par_q ^ rx_odd_q;
                    rx_state_d = RX_STOP;
                end
            end
            RX_STOP: begin
                if (rx_samp) begin
                    rx_push    = 1'b1;
                    rx_state_d = rx_line ? RX_IDLE : RX_WAIT_HIGH;
                end
            end
            RX_WAIT_HIGH: if (rx_line) rx_state_d = RX_IDLE;
            default:      rx_state_d = RX_IDLE;
        endcase
        rx_ovr_d = rx_push && rx_fifo_full && !(rx_valid_o && rx_ready_i);
    end

    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            rx_sync_q  <= 2'b11;
            rx_state_q <= RX_IDLE;
            rx_cnt_q   <= '0;
            rx_div_q   <= DIV_W'(4);
            rx_bit_q   <= '0;
            rx_last_q  <= '0;
            rx_data_q  <= '0;
            rx_pen_q   <= 1'b0;
            rx_odd_q   <= 1'b0;
            rx_par_q   <= 1'b0;
            rx_perr_q  <= 1'b0;
            rx_ovr_q   <= 1'b0;
        end else begin
            rx_sync_q  <= {rx_sync_q[0], rx_i};
            rx_state_q <= rx_state_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_div_q   <= rx_div_d;
            rx_bit_q   <= rx_bit_d;
            rx_last_q  <= rx_last_d;
            rx_data_q  <= rx_data_d;
            rx_pen_q   <= rx_pen_d;
            rx_odd_q   <= rx_odd_d;
            rx_par_q   <= rx_par_d;
            rx_perr_q  <= rx_perr_d;
            rx_ovr_q   <= rx_ovr_d;
        end
    end

    uart_fifo #(.DEPTH(RX_FIFO_DEPTH), .W(10)) u_rx_fifo (
        .clk_i   (clk_i),
        .arst_ni (arst_ni),
        .push_i  (rx_push),
        .wdat_i  ({rx_data_q, rx_perr_q, !rx_line}),
        .pop_i   (rx_ready_i),
        .rdat_o  ({rx_data_o, rx_parity_err_o, rx_frame_err_o}),
        .full_o  (rx_fifo_full),
        .empty_o (rx_fifo_empty),
        .count_o (rx_count_o)
    );

    assign rx_valid_o   = !rx_fifo_empty;
    assign rx_overrun_o = rx_ovr_q;
endmodule

// File: tb/tb_uart_core.sv
// Scenario bench for uart_core: TX waveforms, loopback, RX errors, glitch rejection, overrun, backpressure and reset.
`timescale 1ns/1ps
module tb_uart_core;
    localparam int TXD = 4;
    localparam int RXD = 4;
    localparam int DW  = 16;

    logic                   clk_i = 1'b0;
    logic                   arst_ni;
    logic [DW-1:0]          clk_div_i;
    logic [1:0]             data_bits_i;
    logic                   parity_en_i, parity_type_i, stop2_i;
    logic [7:0]             tx_data_i;
    logic                   tx_valid_i, tx_ready_o, tx_busy_o;
    logic [$clog2(TXD):0]   tx_count_o;
    logic [7:0]             rx_data_o;
    logic                   rx_parity_err_o, rx_frame_err_o, rx_valid_o, rx_ready_i, rx_overrun_o;
    logic [$clog2(RXD):0]   rx_count_o;
    logic                   tx_o, rx_i;
    logic                   loop_en, rx_drv;

    int n_cmp = 0;
    int n_bad = 0;
    int ovr_cnt = 0;
    logic [9:0] sb_q [$];

    always #5 clk_i = ~clk_i;
    assign rx_i = loop_en ? tx_o : rx_drv;

    uart_core #(.TX_FIFO_DEPTH(TXD), .RX_FIFO_DEPTH(RXD), .DIV_W(DW)) dut (
        .clk_i(clk_i), .arst_ni(arst_ni), .clk_div_i(clk_div_i), .data_bits_i(data_bits_i),
        .parity_en_i(parity_en_i), .parity_type_i(parity_type_i), .stop2_i(stop2_i),
        .tx_data_i(tx_data_i), .tx_valid_i(tx_valid_i), .tx_ready_o(tx_ready_o),
        .tx_count_o(tx_count_o), .tx_busy_o(tx_busy_o), .rx_data_o(rx_data_o),
        .rx_parity_err_o(rx_parity_err_o), .rx_frame_err_o(rx_frame_err_o),
        .rx_valid_o(rx_valid_o), .rx_ready_i(rx_ready_i), .rx_count_o(rx_count_o),
        .rx_overrun_o(rx_overrun_o), .tx_o(tx_o), .rx_i(rx_i)
    );

    task automatic tick();
        @(posedge clk_i);
        #1;
        if (rx_overrun_o) ovr_cnt++;
    endtask

    task automatic set_cfg(input int div, input logic [1:0] db, input logic pen, input logic odd, input logic s2);
        clk_div_i     = DW'(div);
        data_bits_i   = db;
        parity_en_i   = pen;
        parity_type_i = odd;
        stop2_i       = s2;
    endtask

    function automatic logic exp_par(input logic [7:0] b, input int nb, input logic odd);
        logic p;
        p = odd;
        for (int i = 0; i < nb; i++) p ^= b[i];
        return p;
    endfunction

    task automatic send_frame(input logic [7:0] b, input int nb, input logic pen, input logic pbit,
                              input logic sbit, input int div);
        rx_drv = 1'b0;
        repeat (div) tick();
        for (int i = 0; i < nb; i++) begin
            rx_drv = b[i];
            repeat (div) tick();
        end
        if (pen) begin
            rx_drv = pbit;
            repeat (div) tick();
        end
        rx_drv = sbit;
        repeat (div) tick();
        rx_drv = 1'b1;
    endtask

    task automatic scoreboard_drain(input string name, input int n);
        logic [9:0] exp;
        int t;
        for (int k = 0; k < n; k++) begin
            t = 0;
            while (!rx_valid_o && t < 3000) begin
                tick();
                t++;
            end
            exp = (sb_q.size() != 0) ? sb_q.pop_front() : 10'h3FF;
            n_cmp++;
            if (!rx_valid_o) begin
                n_bad++;
                $display("FAIL %s[%0d]: rx_valid_o never rose, wanted data=%h perr=%b ferr=%b",
                         name, k, exp[9:2], exp[1], exp[0]);
            end else if ({rx_data_o, rx_parity_err_o, rx_frame_err_o} !== exp) begin
                n_bad++;
                $display("FAIL %s[%0d]: got data=%h perr=%b ferr=%b, wanted data=%h perr=%b ferr=%b",
                         name, k, rx_data_o, rx_parity_err_o, rx_frame_err_o, exp[9:2], exp[1], exp[0]);
            end
            if (rx_valid_o) begin
                rx_ready_i = 1'b1;
                tick();
                rx_ready_i = 1'b0;
            end
        end
    endtask

    task automatic test_reset();
        arst_ni = 1'b0;
        repeat (3) tick();
        n_cmp++;
        if ({tx_o, tx_ready_o, tx_busy_o, rx_valid_o} !== 4'b1100) begin
            n_bad++;
            $display("FAIL reset_ctrl: tx_o/ready/busy/rx_valid=%b, wanted 1100",
                     {tx_o, tx_ready_o, tx_busy_o, rx_valid_o});
        end
        n_cmp++;
        if ({rx_data_o, rx_parity_err_o, rx_frame_err_o, rx_overrun_o} !== 11'h0) begin
            n_bad++;
            $display("FAIL reset_rx: data=%h perr=%b ferr=%b ovr=%b, wanted all 0",
                     rx_data_o, rx_parity_err_o, rx_frame_err_o, rx_overrun_o);
        end
        n_cmp++;
        if (tx_count_o !== '0 || rx_count_o !== '0) begin
            n_bad++;
            $display("FAIL reset_counts: tx=%0d rx=%0d, wanted 0/0", tx_count_o, rx_count_o);
        end
        #2 arst_ni = 1'b1;
        repeat (3) tick();
    endtask

    // Push one byte into an idle TX and compare the line and busy waveforms from the expected fall cycle on.
    task automatic test_tx_frame(input string name, input logic [7:0] b, input logic [1:0] db,
                                 input logic pen, input logic odd, input logic s2, input int div);
        logic [399:0] exp_w, got_w, exp_b, got_b;
        logic bl [16];
        int de, nb, n, len;
        de = (div < 4) ? 4 : div;
        nb = int'(db) + 5;
        n = 0;
        bl[n++] = 1'b0;
        for (int i = 0; i < nb; i++) bl[n++] = b[i];
        if (pen) bl[n++] = exp_par(b, nb, odd);
        bl[n++] = 1'b1;
        if (s2) bl[n++] = 1'b1;
        len = n * de + 10;
        exp_w = '1;
        exp_b = '0;
        for (int c = 0; c < n * de; c++) begin
            exp_w[c] = bl[c / de];
            exp_b[c] = 1'b1;
        end
        got_w = '1;
        got_b = '0;
        set_cfg(div, db, pen, odd, s2);
        tx_data_i  = b;
        tx_valid_i = 1'b1;
        tick();
        tx_valid_i = 1'b0;
        n_cmp++;
        if (tx_o !== 1'b1) begin
            n_bad++;
            $display("FAIL %s_early: tx_o=%b one cycle after push, wanted 1", name, tx_o);
        end
        tick();
        for (int c = 0; c < len; c++) begin
            got_w[c] = tx_o;
            got_b[c] = tx_busy_o;
            tick();
        end
        n_cmp++;
        if (got_w !== exp_w) begin
            n_bad++;
            $display("FAIL %s_line: got %h wanted %h", name, got_w, exp_w);
        end
        n_cmp++;
        if (got_b !== exp_b) begin
            n_bad++;
            $display("FAIL %s_busy: got %h wanted %h", name, got_b, exp_b);
        end
    endtask

    task automatic test_loopback_7e2();
        logic [399:0] exp_w, got_w;
        logic [7:0] bytes [3];
        int c;
        bytes[0] = 8'h5A;
        bytes[1] = 8'h25;
        bytes[2] = 8'h7F;
        exp_w = '1;
        c = 0;
        for (int f = 0; f < 3; f++) begin
            logic bl [11];
            bl[0] = 1'b0;
            for (int i = 0; i < 7; i++) bl[i + 1] = bytes[f][i];
            bl[8]  = exp_par(bytes[f], 7, 1'b0);
            bl[9]  = 1'b1;
            bl[10] = 1'b1;
            for (int k = 0; k < 110; k++) exp_w[c++] = bl[k / 10];
            sb_q.push_back({bytes[f] & 8'h7F, 2'b00});
        end
        got_w = '1;
        set_cfg(10, 2'd2, 1'b1, 1'b0, 1'b1);
        loop_en    = 1'b1;
        rx_ready_i = 1'b0;
        tx_data_i  = bytes[0];
        tx_valid_i = 1'b1;
        tick();
        tx_data_i = bytes[1];
        tick();
        tx_data_i = bytes[2];
        for (int k = 0; k < 340; k++) begin
            got_w[k] = tx_o;
            tick();
            tx_valid_i = 1'b0;
        end
        n_cmp++;
        if (got_w !== exp_w) begin
            n_bad++;
            $display("FAIL loop_line: got %h wanted %h", got_w, exp_w);
        end
        scoreboard_drain("loop_rx", 3);
        n_cmp++;
        if (rx_count_o !== '0) begin
            n_bad++;
            $display("FAIL loop_empty: rx_count_o=%0d, wanted 0", rx_count_o);
        end
        loop_en = 1'b0;
        repeat (20) tick();
    endtask

    task automatic test_rx_errors();
        set_cfg(16, 2'd3, 1'b1, 1'b1, 1'b0);
        sb_q.push_back({8'h00, 2'b10});
        send_frame(8'h00, 8, 1'b1, 1'b0, 1'b1, 16);
        repeat (20) tick();
        sb_q.push_back({8'h81, 2'b01});
        send_frame(8'h81, 8, 1'b1, exp_par(8'h81, 8, 1'b1), 1'b0, 16);
        // Line stays low well past the bad stop bit; this must not start a frame.
        rx_drv = 1'b0;
        repeat (48) tick();
        rx_drv = 1'b1;
        repeat (32) tick();
        sb_q.push_back({8'h42, 2'b00});
        send_frame(8'h42, 8, 1'b1, exp_par(8'h42, 8, 1'b1), 1'b1, 16);
        repeat (20) tick();
        n_cmp++;
        if (rx_count_o !== 3'd3) begin
            n_bad++;
            $display("FAIL err_count: rx_count_o=%0d, wanted 3", rx_count_o);
        end
        scoreboard_drain("err_rx", 3);
    endtask

    task automatic test_glitch();
        set_cfg(16, 2'd3, 1'b0, 1'b0, 1'b0);
        rx_drv = 1'b0;
        repeat (4) tick();
        rx_drv = 1'b1;
        repeat (40) tick();
        n_cmp++;
        if (rx_count_o !== '0 || rx_valid_o !== 1'b0) begin
            n_bad++;
            $display("FAIL glitch_nopush: rx_count_o=%0d rx_valid_o=%b, wanted 0/0", rx_count_o, rx_valid_o);
        end
        sb_q.push_back({8'h3C, 2'b00});
        send_frame(8'h3C, 8, 1'b0, 1'b0, 1'b1, 16);
        repeat (20) tick();
        scoreboard_drain("glitch_rx", 1);
    endtask

    task automatic test_overrun();
        set_cfg(8, 2'd3, 1'b0, 1'b0, 1'b0);
        rx_ready_i = 1'b0;
        ovr_cnt    = 0;
        for (int v = 1; v <= 5; v++) begin
            if (v <= RXD) sb_q.push_back({8'(v), 2'b00});
            send_frame(8'(v), 8, 1'b0, 1'b0, 1'b1, 8);
            repeat (4) tick();
        end
        repeat (10) tick();
        n_cmp++;
        if (rx_count_o !== 3'd4) begin
            n_bad++;
            $display("FAIL ovr_count: rx_count_o=%0d, wanted 4", rx_count_o);
        end
        n_cmp++;
        if (ovr_cnt != 1) begin
            n_bad++;
            $display("FAIL ovr_pulse: rx_overrun_o high for %0d cycles, wanted 1", ovr_cnt);
        end
        scoreboard_drain("ovr_rx", 4);
        n_cmp++;
        if (rx_valid_o !== 1'b0) begin
            n_bad++;
            $display("FAIL ovr_drained: rx_valid_o=%b after draining, wanted 0", rx_valid_o);
        end
    endtask

    task automatic test_backpressure_reset();
        int acc;
        set_cfg(100, 2'd3, 1'b0, 1'b0, 1'b0);
        acc = 0;
        for (int k = 0; k < 5; k++) begin
            tx_data_i  = 8'h10 + 8'(k);
            tx_valid_i = 1'b1;
            if (tx_ready_o) acc++;
            tick();
        end
        tx_valid_i = 1'b0;
        n_cmp++;
        if (acc != 5) begin
            n_bad++;
            $display("FAIL bp_accept: %0d pushes accepted, wanted 5", acc);
        end
        n_cmp++;
        if (tx_count_o !== 3'd4 || tx_ready_o !== 1'b0) begin
            n_bad++;
            $display("FAIL bp_full: tx_count_o=%0d tx_ready_o=%b, wanted 4/0", tx_count_o, tx_ready_o);
        end
        tx_data_i  = 8'hEE;
        tx_valid_i = 1'b1;
        tick();
        tx_valid_i = 1'b0;
        n_cmp++;
        if (tx_count_o !== 3'd4) begin
            n_bad++;
            $display("FAIL bp_reject: tx_count_o=%0d after push while full, wanted 4", tx_count_o);
        end
        repeat (250) tick();
        n_cmp++;
        if (tx_busy_o !== 1'b1 || tx_o !== 1'b0) begin
            n_bad++;
            $display("FAIL bp_midframe: tx_busy_o=%b tx_o=%b, wanted 1/0", tx_busy_o, tx_o);
        end
        #2 arst_ni = 1'b0;
        #1;
        n_cmp++;
        if (tx_o !== 1'b1 || tx_busy_o !== 1'b0) begin
            n_bad++;
            $display("FAIL rst_line: tx_o=%b tx_busy_o=%b during reset, wanted 1/0", tx_o, tx_busy_o);
        end
        n_cmp++;
        if (tx_count_o !== '0 || tx_ready_o !== 1'b1) begin
            n_bad++;
            $display("FAIL rst_flush: tx_count_o=%0d tx_ready_o=%b during reset, wanted 0/1", tx_count_o, tx_ready_o);
        end
        #1 arst_ni = 1'b1;
        repeat (20) tick();
        n_cmp++;
        if (tx_o !== 1'b1 || tx_busy_o !== 1'b0 || tx_count_o !== '0) begin
            n_bad++;
            $display("FAIL rst_after: tx_o=%b busy=%b count=%0d, wanted 1/0/0", tx_o, tx_busy_o, tx_count_o);
        end
    endtask

    initial begin
        arst_ni    = 1'b0;
        tx_valid_i = 1'b0;
        tx_data_i  = '0;
        rx_ready_i = 1'b0;
        rx_drv     = 1'b1;
        loop_en    = 1'b0;
        set_cfg(16, 2'd3, 1'b0, 1'b0, 1'b0);
        test_reset();
        test_tx_frame("tx_8n1", 8'hA5, 2'd3, 1'b0, 1'b0, 1'b0, 16);
        test_tx_frame("tx_clamp_5e2", 8'hFF, 2'd0, 1'b1, 1'b0, 1'b1, 1);
        test_loopback_7e2();
        test_rx_errors();
        test_glitch();
        test_overrun();
        test_backpressure_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end
endmodule
